// File: rtl/haraka_s_sponge_ctrl.sv
// rtl/haraka_s_sponge_ctrl.sv - Haraka-S sponge controller
// Absorbs padded 256-bit rate blocks, sequences the external round core, squeezes digest blocks.
module haraka_s_sponge_ctrl #(
   parameter int PERM_ROUNDS   = 5,
   parameter int ROUND_LATENCY = 2,
   parameter int OUT_BLOCKS    = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         msg_valid,
   output logic         msg_ready,
   input  logic [255:0] msg_data,
   input  logic         msg_last,
   input  logic [5:0]   msg_bytes,
   output logic [511:0] perm_in,
   output logic         perm_sel,
   input  logic [511:0] perm_out,
   output logic         dig_valid,
   input  logic         dig_ready,
   output logic [255:0] dig_data,
   output logic         dig_last,
   output logic         busy
);

   localparam int RW = $clog2(PERM_ROUNDS) + 1;
   localparam int LW = $clog2(ROUND_LATENCY) + 1;
   localparam int BW = $clog2(OUT_BLOCKS) + 1;
   localparam logic [255:0] PAD_BLK = {8'h1F, 240'h0, 8'h80};

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PERM    = 2'd1,
      PAD     = 2'd2,
      SQUEEZE = 2'd3
   } fsm_t;

   fsm_t          fsm;
   fsm_t          fsm_next;
   logic [511:0]  state;
   logic [RW-1:0] rnd;
   logic [LW-1:0] lat;
   logic [BW-1:0] blk;
   logic          last_seen;
   logic          pad_pending;

   logic [5:0]    n_clamp;
   logic [255:0]  pad_block;
   logic          full_last;
   logic          round_done;
   logic          perm_done;
   logic          blk_final;

   // Round core feedback is owned here, so the core's own mux stays on the external path.
   assign perm_sel = 1'b0;

   assign n_clamp    = (msg_bytes > 6'd32) ? 6'd32 : msg_bytes;
   assign full_last  = msg_last && (n_clamp == 6'd32);
   assign round_done = (fsm == PERM) && (lat == LW'(ROUND_LATENCY - 1));
   assign perm_done  = round_done && (rnd == RW'(PERM_ROUNDS - 1));
   assign blk_final  = (blk == BW'(OUT_BLOCKS - 1));

   // Final-block padding: bytes past the valid count are discarded, not trusted to be zero.
   always_comb begin
      pad_block = msg_data;
      for (int i = 0; i < 32; i++) begin
         if (msg_last && (i >= int'(n_clamp))) begin
            pad_block[255-8*i -: 8] = 8'h00;
         end
         if (msg_last && (i == int'(n_clamp))) begin
            pad_block[255-8*i -: 8] = pad_block[255-8*i -: 8] ^ 8'h1F;
         end
      end
      if (msg_last && (n_clamp != 6'd32)) begin
         pad_block[7:0] = pad_block[7:0] ^ 8'h80;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fsm <= IDLE;
      end else begin
         fsm <= fsm_next;
      end
   end

   always_comb begin
      fsm_next  = fsm;
      msg_ready = 1'b0;
      busy      = 1'b1;
      dig_valid = 1'b0;
      dig_last  = 1'b0;
      dig_data  = '0;
      perm_in   = '0;
      case (fsm)
         IDLE: begin
            msg_ready = 1'b1;
            busy      = 1'b0;
            if (msg_valid) begin
               fsm_next = PERM;
            end
         end
         PERM: begin
            perm_in = state;
            if (perm_done) begin
               if (!last_seen) begin
                  fsm_next = IDLE;
               end else if (pad_pending) begin
                  fsm_next = PAD;
               end else begin
                  fsm_next = SQUEEZE;
               end
            end
         end
         PAD: begin
            fsm_next = PERM;
         end
         SQUEEZE: begin
            dig_valid = 1'b1;
            dig_data  = state[511:256];
            dig_last  = blk_final;
            if (dig_ready) begin
               fsm_next = blk_final ? IDLE : PERM;
            end
         end
         default: begin
            fsm_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= '0;
         rnd         <= '0;
         lat         <= '0;
         blk         <= '0;
         last_seen   <= 1'b0;
         pad_pending <= 1'b0;
      end else begin
         case (fsm)
            IDLE: begin
               if (msg_valid) begin
                  state[511:256] <= state[511:256] ^ pad_block;
                  last_seen      <= msg_last;
                  pad_pending    <= full_last;
                  rnd            <= '0;
                  lat            <= '0;
               end
            end
            PERM: begin
               if (round_done) begin
                  state <= perm_out;
                  lat   <= '0;
                  rnd   <= perm_done ? '0 : rnd + RW'(1);
               end else begin
                  lat <= lat + LW'(1);
               end
            end
            PAD: begin
               state[511:256] <= state[511:256] ^ PAD_BLK;
               pad_pending    <= 1'b0;
            end
            SQUEEZE: begin
               if (dig_ready) begin
                  if (blk_final) begin
                     state     <= '0;
                     blk       <= '0;
                     last_seen <= 1'b0;
                  end else begin
                     blk <= blk + BW'(1);
                  end
               end
            end
            default: begin
               state <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_haraka_s_sponge_ctrl.sv
// tb/tb_haraka_s_sponge_ctrl.sv - scoreboard bench for haraka_s_sponge_ctrl
// Stand-in round core plus a byte-level sponge model computing expected digests.
module tb_haraka_s_sponge_ctrl;

   localparam int PR = 5;
   localparam int RL = 2;
   localparam int OB = 2;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         msg_valid;
   logic         msg_ready;
   logic [255:0] msg_data;
   logic         msg_last;
   logic [5:0]   msg_bytes;
   logic [511:0] perm_in;
   logic         perm_sel;
   logic [511:0] perm_out;
   logic         dig_valid;
   logic         dig_ready;
   logic [255:0] dig_data;
   logic         dig_last;
   logic         busy;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int acc_cyc = 0;
   int mode  = 0;
   logic [256:0] exp_q[$];
   logic [7:0]   msg_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [511:0] round_f(input logic [511:0] x);
      logic [511:0] k;
      k = {16{32'h9E3779B9}};
      return ({x[474:0], x[511:475]} ^ k) + {x[255:0], x[511:256]};
   endfunction

   function automatic logic [511:0] permute(input logic [511:0] x);
      logic [511:0] y;
      y = x;
      for (int r = 0; r < PR; r++) y = round_f(y);
      return y;
   endfunction

   function automatic logic [255:0] pack(input logic [7:0] b[32]);
      logic [255:0] d;
      for (int i = 0; i < 32; i++) d[255-8*i -: 8] = b[i];
      return d;
   endfunction

   assign perm_out = round_f(perm_in);

   haraka_s_sponge_ctrl #(
      .PERM_ROUNDS(PR), .ROUND_LATENCY(RL), .OUT_BLOCKS(OB)
   ) dut (
      .clk(clk), .rst_n(rst_n), .msg_valid(msg_valid), .msg_ready(msg_ready),
      .msg_data(msg_data), .msg_last(msg_last), .msg_bytes(msg_bytes),
      .perm_in(perm_in), .perm_sel(perm_sel), .perm_out(perm_out),
      .dig_valid(dig_valid), .dig_ready(dig_ready), .dig_data(dig_data),
      .dig_last(dig_last), .busy(busy)
   );

   // Sink back-pressure: 0 always ready, 1 random, 2 stalled.
   initial begin
      dig_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         case (mode)
            0:       dig_ready = 1'b1;
            1:       dig_ready = 1'($urandom);
            default: dig_ready = 1'b0;
         endcase
      end
   end

   always @(negedge clk) begin
      if (rst_n && dig_valid) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL digest_unexpected: got %h want no block", dig_data);
         end else begin
            if ({dig_last, dig_data} !== exp_q[0]) begin
               bad++;
               $display("FAIL digest: got last=%0b %h want last=%0b %h",
                        dig_last, dig_data, exp_q[0][256], exp_q[0][255:0]);
            end
            if (dig_ready) exp_q.delete(0);
         end
      end
   end

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic send_block(input logic [255:0] d, input logic last, input logic [5:0] nb);
      int k;
      @(posedge clk);
      #1;
      msg_data  = d;
      msg_last  = last;
      msg_bytes = nb;
      msg_valid = 1'b1;
      for (k = 0; k < 300; k++) begin
         @(negedge clk);
         if (msg_ready) break;
      end
      if (k == 300) chk("accept_timeout", 256'(0), 256'(1));
      acc_cyc = cyc;
      @(posedge clk);
      #1;
      msg_valid = 1'b0;
   endtask

   task automatic send_msg(input int nb_ovr, input bit push, input bit poke);
      int len;
      int nblk;
      logic [511:0] st;
      logic [255:0] bd[$];
      logic [5:0]   bn[$];
      len  = msg_q.size();
      nblk = (len == 0) ? 1 : (len + 31) / 32;
      st   = '0;
      for (int j = 0; j < nblk; j++) begin
         logic [7:0] b[32];
         logic [7:0] a[32];
         int nb, nf, n;
         bit last;
         last = (j == nblk - 1);
         for (int i = 0; i < 32; i++) b[i] = (32*j + i < len) ? msg_q[32*j + i] : 8'($urandom);
         nb = last ? len - 32*j : 32;
         nf = (last && nb_ovr >= 0) ? nb_ovr : nb;
         n  = (nf > 32) ? 32 : nf;
         for (int i = 0; i < 32; i++) a[i] = (!last || i < n) ? b[i] : 8'h00;
         if (last && n < 32) begin
            a[n]  = a[n] ^ 8'h1F;
            a[31] = a[31] ^ 8'h80;
         end
         bd.push_back(pack(b));
         bn.push_back(6'(nf));
         st[511:256] = st[511:256] ^ pack(a);
         st = permute(st);
         if (last && n == 32) begin
            st[511:256] = st[511:256] ^ {8'h1F, 240'h0, 8'h80};
            st = permute(st);
         end
      end
      if (push) begin
         for (int k = 0; k < OB; k++) begin
            exp_q.push_back({(k == OB - 1), st[511:256]});
            if (k < OB - 1) st = permute(st);
         end
      end
      for (int j = 0; j < nblk; j++) send_block(bd[j], (j == nblk - 1), bn[j]);
      if (poke) begin
         msg_valid = 1'b1;
         msg_last  = 1'b1;
         msg_bytes = 6'd3;
         msg_data  = {8{$urandom}};
         for (int p = 0; p < 4; p++) begin
            @(negedge clk);
            chk("ready_in_perm", 256'(msg_ready), 256'(0));
         end
         @(posedge clk);
         #1;
         msg_valid = 1'b0;
      end
   endtask

   task automatic wait_dig(output int lat);
      int k;
      for (k = 0; k < 300; k++) begin
         @(negedge clk);
         if (dig_valid) break;
      end
      if (k == 300) chk("dig_timeout", 256'(0), 256'(1));
      lat = cyc - acc_cyc;
   endtask

   task automatic wait_drain();
      int k;
      for (k = 0; k < 3000; k++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !busy) break;
      end
      if (k == 3000) chk("drain_timeout", 256'(exp_q.size()), 256'(0));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int lat;
      int h;
      int k;
      rst_n = 1'b0; msg_valid = 1'b0; msg_data = '0; msg_last = 1'b0; msg_bytes = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_msg_ready", 256'(msg_ready), 256'(1));
      chk("rst_busy", 256'(busy), 256'(0));
      chk("rst_dig_valid", 256'(dig_valid), 256'(0));
      chk("rst_dig_last", 256'(dig_last), 256'(0));
      chk("rst_perm_sel", 256'(perm_sel), 256'(0));
      chk("rst_perm_in", perm_in[511:256] | perm_in[255:0], 256'(0));

      // empty message
      msg_q.delete();
      send_msg(-1, 1'b1, 1'b0);
      @(negedge clk);
      chk("empty_absorb", perm_in[511:256], {8'h1F, 240'h0, 8'h80});
      wait_dig(lat);
      chk("empty_latency", 256'(lat), 256'(11));
      wait_drain();

      // exact 32-byte message: full block then a PAD block
      msg_q.delete();
      for (int i = 0; i < 32; i++) msg_q.push_back(8'($urandom));
      send_msg(-1, 1'b1, 1'b0);
      wait_dig(lat);
      chk("full_latency", 256'(lat), 256'(22));
      wait_drain();

      // 31-byte message: pad bytes collide in byte 31
      msg_q.delete();
      for (int i = 0; i < 31; i++) msg_q.push_back(8'($urandom));
      send_msg(-1, 1'b1, 1'b0);
      @(negedge clk);
      chk("b31_pad", 256'(perm_in[263:256]), 256'(8'h9F));
      wait_dig(lat);
      chk("b31_latency", 256'(lat), 256'(11));
      wait_drain();

      // byte count above 32 behaves as 32
      msg_q.delete();
      for (int i = 0; i < 64; i++) msg_q.push_back(8'($urandom));
      send_msg(45, 1'b1, 1'b0);
      wait_drain();

      // two-block message, sink stalled with msg_valid poked during SQUEEZE
      mode = 2;
      msg_q.delete();
      for (int i = 0; i < 40; i++) msg_q.push_back(8'($urandom));
      send_msg(-1, 1'b1, 1'b0);
      wait_dig(lat);
      for (int p = 0; p < 5; p++) begin
         @(posedge clk);
         #1;
         msg_valid = 1'b1;
         msg_last  = 1'b1;
         msg_data  = {8{$urandom}};
         @(negedge clk);
         chk("ready_in_squeeze", 256'(msg_ready), 256'(0));
         chk("stall_valid", 256'(dig_valid), 256'(1));
      end
      @(posedge clk);
      #1;
      msg_valid = 1'b0;
      mode = 0;
      for (k = 0; k < 20; k++) begin
         @(negedge clk);
         if (dig_valid && dig_ready) break;
      end
      h = cyc;
      for (k = 0; k < 60; k++) begin
         @(negedge clk);
         if (dig_valid) break;
      end
      chk("squeeze_gap", 256'(cyc - h), 256'(PR * RL + 1));
      wait_drain();

      // reset during round 3 discards the message
      msg_q.delete();
      for (int i = 0; i < 10; i++) msg_q.push_back(8'($urandom));
      send_msg(-1, 1'b0, 1'b0);
      repeat (6) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("midrst_msg_ready", 256'(msg_ready), 256'(1));
      chk("midrst_busy", 256'(busy), 256'(0));
      chk("midrst_dig_valid", 256'(dig_valid), 256'(0));

      // "abc" after reset, with msg_valid poked during PERM
      msg_q.delete();
      msg_q.push_back(8'h61); msg_q.push_back(8'h62); msg_q.push_back(8'h63);
      send_msg(-1, 1'b1, 1'b1);
      wait_drain();

      // randomized messages under random back-pressure
      mode = 1;
      for (int m = 0; m < 16; m++) begin
         int len;
         int ovr;
         len = $urandom_range(0, 100);
         if (m == 3) len = 96;
         msg_q.delete();
         for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom));
         ovr = (len > 0 && len % 32 == 0 && ($urandom % 2 == 1)) ? $urandom_range(33, 63) : -1;
         send_msg(ovr, 1'b1, 1'b0);
      end
      wait_drain();
      mode = 0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
